// File: rtl/cpu_bus_master_if.sv
// External memory bus seen by cpu_bus_master: strobe, write enable, address,
// write data out; read data and per-beat ready back from the slave.
interface cpu_bus_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
);
  logic                  o_bus_clk;
  logic                  o_bus_we;
  logic [ADDR_WIDTH-1:0] o_bus_addr;
  logic [DATA_WIDTH-1:0] o_bus_data;
  logic [DATA_WIDTH-1:0] i_bus_data;
  logic                  i_bus_data_ready;

  modport master (
    output o_bus_clk,
    output o_bus_we,
    output o_bus_addr,
    output o_bus_data,
    input  i_bus_data,
    input  i_bus_data_ready
  );

  modport slave (
    input  o_bus_clk,
    input  o_bus_we,
    input  o_bus_addr,
    input  o_bus_data,
    output i_bus_data,
    output i_bus_data_ready
  );
endinterface

// File: rtl/cpu_bus_master.sv
// cpu_bus_master: multi-beat load/store engine between the core's load/store
// sequencer and the external memory bus. One request moves up to MAX_BEATS
// bus beats, ascending or descending in address, while the operand stays
// little-endian in memory. Each beat is a strobe-high phase (held until the
// slave signals ready) followed by a single strobe-low cycle.
// Optional feature macro: BUS_TIMEOUT_EN (abort a beat after TIMEOUT_CYCLES
// strobe cycles without ready and flag o_error alongside o_done).
module cpu_bus_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 8,
  parameter int MAX_BEATS      = 4,
  parameter int BEAT_W         = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_req,
  input  logic                            i_we,
  input  logic [ADDR_WIDTH-1:0]           i_addr,
  input  logic [MAX_BEATS*DATA_WIDTH-1:0] i_wdata,
  input  logic [BEAT_W-1:0]               i_beats,
  input  logic                            i_descend,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_error,
  output logic [MAX_BEATS*DATA_WIDTH-1:0] o_rdata,
  cpu_bus_master_if.master                bus
);

  if (BEAT_W < $clog2(MAX_BEATS + 1)) begin : g_chk_beat_w
    $error("BEAT_W is too narrow to hold MAX_BEATS");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_chk_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_STROBE, S_RELEASE, S_DONE} state_t;

  state_t                          state_q, state_d;
  logic                            we_q, desc_q;
  logic [ADDR_WIDTH-1:0]           addr_q;
  logic [MAX_BEATS*DATA_WIDTH-1:0] wdata_q;
  logic [BEAT_W-1:0]               beats_q, k_q;

  logic                            accept, beat_ack, last_beat, abort, err_flag;
  logic [BEAT_W-1:0]               beats_clamped, byte_idx;
  logic [ADDR_WIDTH-1:0]           beat_addr;
  logic [DATA_WIDTH-1:0]           sel_byte;

  assign accept        = (state_q == S_IDLE) && i_req;
  assign beat_ack      = (state_q == S_STROBE) && bus.i_bus_data_ready;
  assign last_beat     = (k_q + BEAT_W'(1)) == beats_q;
  assign beats_clamped = (i_beats > BEAT_W'(MAX_BEATS)) ? BEAT_W'(MAX_BEATS) : i_beats;
  // Descending transfers walk the operand from its top byte so the memory
  // image stays little-endian regardless of address direction.
  assign byte_idx      = desc_q ? (beats_q - BEAT_W'(1) - k_q) : k_q;
  assign beat_addr     = desc_q ? (addr_q - ADDR_WIDTH'(k_q)) : (addr_q + ADDR_WIDTH'(k_q));

  // Pick the store byte for the current beat out of the latched operand
  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < MAX_BEATS; i++) begin
      if (byte_idx == BEAT_W'(i)) sel_byte = wdata_q[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

`ifdef BUS_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WAIT_W-1:0] wait_q;
  logic              err_q;

  assign abort    = (state_q == S_STROBE) && !bus.i_bus_data_ready &&
                    (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1));
  assign err_flag = err_q;

  // Count strobe cycles without ready; outside STROBE the count sits at zero
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q != S_STROBE)        wait_q <= '0;
      else if (!bus.i_bus_data_ready) wait_q <= wait_q + WAIT_W'(1);
      if (accept)     err_q <= 1'b0;
      else if (abort) err_q <= 1'b1;
    end
  end
`else
  assign abort    = 1'b0;
  assign err_flag = 1'b0;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode and bus/handshake outputs
  always_comb begin
    state_d        = state_q;
    o_busy         = (state_q != S_IDLE);
    o_done         = 1'b0;
    o_error        = 1'b0;
    bus.o_bus_clk  = 1'b0;
    bus.o_bus_we   = 1'b0;
    bus.o_bus_addr = '0;
    bus.o_bus_data = '0;
    unique case (state_q)
      S_IDLE: begin
        if (i_req) state_d = (i_beats == '0) ? S_DONE : S_STROBE;
      end
      S_STROBE: begin
        bus.o_bus_clk  = 1'b1;
        bus.o_bus_we   = we_q;
        bus.o_bus_addr = beat_addr;
        bus.o_bus_data = sel_byte;
        if (abort)                     state_d = S_DONE;
        else if (bus.i_bus_data_ready) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        bus.o_bus_we   = we_q;
        bus.o_bus_addr = beat_addr;
        bus.o_bus_data = sel_byte;
        state_d        = last_beat ? S_DONE : S_STROBE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        o_error = err_flag;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, beat counter and load-data assembly
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q    <= 1'b0;
      desc_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      beats_q <= '0;
      k_q     <= '0;
      o_rdata <= '0;
    end else if (accept) begin
      we_q    <= i_we;
      desc_q  <= i_descend;
      addr_q  <= i_addr;
      wdata_q <= i_wdata;
      beats_q <= beats_clamped;
      k_q     <= '0;
      o_rdata <= '0;
    end else begin
      if (beat_ack && !we_q) begin
        for (int i = 0; i < MAX_BEATS; i++) begin
          if (byte_idx == BEAT_W'(i)) o_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= bus.i_bus_data;
        end
      end
      if (state_q == S_RELEASE) k_q <= k_q + BEAT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master: a transaction-level model expands each request
// into the expected per-cycle behaviour (strobe phases, addresses, bytes,
// completion) plus the slave's responses; one process replays that schedule.
module tb_cpu_bus_master;
  localparam int AW  = 32;
  localparam int DW  = 8;
  localparam int MB  = 4;
  localparam int BW  = 3;
  localparam int TO  = 8;
  localparam int OPW = MB * DW;

  logic           i_clk = 1'b0;
  logic           i_rst_n, i_req, i_we, i_descend;
  logic [AW-1:0]  i_addr;
  logic [OPW-1:0] i_wdata;
  logic [BW-1:0]  i_beats;
  logic           o_busy, o_done, o_error;
  logic [OPW-1:0] o_rdata;

  always #5 i_clk = ~i_clk;

  cpu_bus_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  cpu_bus_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BEATS(MB), .BEAT_W(BW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_beats(i_beats), .i_descend(i_descend), .o_busy(o_busy),
    .o_done(o_done), .o_error(o_error), .o_rdata(o_rdata), .bus(bus)
  );

  // One record per clock cycle: inputs to apply and outputs to expect.
  typedef struct packed {
    logic           first, rst_n, aschk, req, we, desc;
    logic [AW-1:0]  addr;
    logic [OPW-1:0] wdata;
    logic [BW-1:0]  beats;
    logic           rdy;
    logic [DW-1:0]  bdata;
    logic           e_busy, e_done, e_err, e_clk, e_we, e_chkwe, e_act, e_chkd;
    logic [AW-1:0]  e_addr;
    logic [DW-1:0]  e_data;
    logic [OPW-1:0] e_rdata;
  } rec_t;

  rec_t           q[$];
  rec_t           cr;
  logic [OPW-1:0] m_rdata = '0;
  int             w_tab[MB];
  logic [DW-1:0]  rb_tab[MB];
  int             n_cmp = 0, n_bad = 0;
  int             cidx = 0, done_idx = -1, done_cnt = 0, err_seen = 0;
  logic [AW-1:0]  wlog_a[$];
  logic [DW-1:0]  wlog_d[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask

  function automatic rec_t blank();
    rec_t r;
    r = '0;
    r.rst_n   = 1'b1;
    r.e_chkwe = 1'b1;
    r.e_rdata = m_rdata;
    return r;
  endfunction

  // Random inputs that the DUT must ignore in the cycle they are applied.
  function automatic rec_t noise();
    rec_t r;
    r = blank();
    r.req = 1'($urandom); r.we = 1'($urandom); r.desc = 1'($urandom);
    r.addr = $urandom; r.wdata = $urandom; r.beats = BW'($urandom);
    r.rdy = 1'($urandom); r.bdata = DW'($urandom);
    r.e_chkwe = 1'b0;
    return r;
  endfunction

  function automatic rec_t strobe_rec(input logic we, input logic [AW-1:0] a,
                                      input logic [OPW-1:0] wd, input int b,
                                      input logic [OPW-1:0] cur);
    rec_t r;
    r = noise();
    r.e_busy = 1'b1; r.e_clk = 1'b1; r.e_we = we; r.e_chkwe = 1'b1;
    r.e_act = 1'b1; r.e_addr = a; r.e_chkd = we; r.e_data = wd[b*DW +: DW];
    r.e_rdata = cur;
    return r;
  endfunction

  // Expand one request into its cycle schedule. w_tab[k] is the number of
  // strobe cycles until ready for beat k (0 = slave never answers).
  task automatic push_txn(input logic we, input logic [AW-1:0] addr, input logic [OPW-1:0] wd,
                          input logic [BW-1:0] beats, input logic desc);
    rec_t r; int n; int b; int w; bit aborted; logic [AW-1:0] a; logic [OPW-1:0] cur;
    n = (int'(beats) > MB) ? MB : int'(beats);
    r = blank(); r.first = 1'b1; r.req = 1'b1; r.we = we; r.addr = addr;
    r.wdata = wd; r.beats = beats; r.desc = desc;
    q.push_back(r);
    cur = '0; aborted = 1'b0;
    for (int k = 0; k < n && !aborted; k++) begin
      b = desc ? (n - 1 - k) : k;
      a = desc ? (addr - AW'(k)) : (addr + AW'(k));
      w = w_tab[k];
      if (w == 0) begin
        for (int s = 0; s < TO; s++) begin
          r = strobe_rec(we, a, wd, b, cur); r.rdy = 1'b0; q.push_back(r);
        end
        aborted = 1'b1;
      end else begin
        for (int s = 0; s < w; s++) begin
          r = strobe_rec(we, a, wd, b, cur);
          r.rdy = (s == w - 1);
          if (r.rdy) r.bdata = rb_tab[k];
          q.push_back(r);
        end
        if (!we) cur[b*DW +: DW] = rb_tab[k];
        r = strobe_rec(we, a, wd, b, cur); r.e_clk = 1'b0; r.e_chkwe = 1'b0;
        q.push_back(r);
      end
    end
    r = noise(); r.req = 1'b0; r.e_busy = 1'b1; r.e_done = 1'b1; r.e_err = aborted;
    r.e_rdata = cur;
    q.push_back(r);
    m_rdata = cur;
  endtask

  // Held in reset, then a store interrupted by reset inside its first strobe.
  task automatic push_reset_test();
    rec_t r; logic [OPW-1:0] wd;
    wd = $urandom;
    for (int i = 0; i < 3; i++) begin
      r = blank(); r.rst_n = 1'b0; r.first = (i == 0); q.push_back(r);
    end
    r = blank(); r.first = 1'b1; r.req = 1'b1; r.we = 1'b1; r.addr = 32'h40;
    r.wdata = wd; r.beats = 3'd4;
    q.push_back(r);
    r = strobe_rec(1'b1, 32'h40, wd, 0, '0); r.rdy = 1'b0; r.rst_n = 1'b0;
    r.aschk = 1'b1; r.req = 1'b0;
    q.push_back(r);
    for (int i = 0; i < 8; i++) begin
      r = blank(); r.rst_n = (i >= 2); q.push_back(r);
    end
    m_rdata = '0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() != 0 && guard < 5000) begin
      @(posedge i_clk);
      guard++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    #1;
  endtask

  // Replay the schedule: check this cycle's outputs, then drive its inputs.
  initial begin
    i_rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_descend = 1'b0;
    i_addr = '0; i_wdata = '0; i_beats = '0;
    bus.i_bus_data_ready = 1'b0; bus.i_bus_data = '0;
    forever begin
      @(negedge i_clk);
      if (q.size() != 0) begin
        cr = q.pop_front();
        if (cr.first) begin
          cidx = 0; done_idx = -1; done_cnt = 0; err_seen = 0;
        end else begin
          cidx++;
        end
        chk("busy", 64'(o_busy), 64'(cr.e_busy));
        chk("done", 64'(o_done), 64'(cr.e_done));
        chk("error", 64'(o_error), 64'(cr.e_err));
        chk("bus_clk", 64'(bus.o_bus_clk), 64'(cr.e_clk));
        chk("rdata", 64'(o_rdata), 64'(cr.e_rdata));
        if (cr.e_chkwe) chk("bus_we", 64'(bus.o_bus_we), 64'(cr.e_we));
        if (cr.e_act)   chk("bus_addr", 64'(bus.o_bus_addr), 64'(cr.e_addr));
        if (cr.e_chkd)  chk("bus_data", 64'(bus.o_bus_data), 64'(cr.e_data));
        if (o_done) begin
          done_idx = cidx; done_cnt++;
          if (o_error) err_seen = 1;
        end
        if (bus.o_bus_clk && bus.o_bus_we && cr.rdy) begin
          wlog_a.push_back(bus.o_bus_addr);
          wlog_d.push_back(bus.o_bus_data);
        end
        i_rst_n = cr.rst_n; i_req = cr.req; i_we = cr.we; i_descend = cr.desc;
        i_addr = cr.addr; i_wdata = cr.wdata; i_beats = cr.beats;
        bus.i_bus_data_ready = cr.rdy; bus.i_bus_data = cr.bdata;
        if (cr.aschk) begin
          #1;
          chk("rst_async_bus_clk", 64'(bus.o_bus_clk), 64'd0);
          chk("rst_async_bus_we", 64'(bus.o_bus_we), 64'd0);
          chk("rst_async_busy", 64'(o_busy), 64'd0);
          chk("rst_async_done", 64'(o_done), 64'd0);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    push_reset_test();
    drain();
    chk("rst_no_done_after", 64'(done_cnt), 64'd0);

    // Ascending 4-beat load, zero-wait slave
    w_tab = '{1, 1, 1, 1};
    rb_tab = '{8'h11, 8'h22, 8'h33, 8'h44};
    push_txn(1'b0, 32'h0000_1000, 32'($urandom), 3'd4, 1'b0);
    drain();
    chk("t2_rdata", 64'(o_rdata), 64'h4433_2211);
    chk("t2_done_cycle", 64'(done_idx), 64'd9);

    // Descending 4-beat store (stack push)
    wlog_a.delete(); wlog_d.delete();
    push_txn(1'b1, 32'h0000_01FF, 32'hAABB_CCDD, 3'd4, 1'b1);
    drain();
    chk("t3_beats", 64'(wlog_a.size()), 64'd4);
    chk("t3_a0", 64'(wlog_a[0]), 64'h1FF); chk("t3_d0", 64'(wlog_d[0]), 64'hAA);
    chk("t3_a1", 64'(wlog_a[1]), 64'h1FE); chk("t3_d1", 64'(wlog_d[1]), 64'hBB);
    chk("t3_a2", 64'(wlog_a[2]), 64'h1FD); chk("t3_d2", 64'(wlog_d[2]), 64'hCC);
    chk("t3_a3", 64'(wlog_a[3]), 64'h1FC); chk("t3_d3", 64'(wlog_d[3]), 64'hDD);

    // 2-beat store across the address wrap, 3-cycle ready delay per beat
    w_tab = '{3, 3, 1, 1};
    wlog_a.delete(); wlog_d.delete();
    push_txn(1'b1, 32'hFFFF_FFFF, 32'($urandom), 3'd2, 1'b0);
    drain();
    chk("t4_beats", 64'(wlog_a.size()), 64'd2);
    chk("t4_addr0", 64'(wlog_a[0]), 64'hFFFF_FFFF);
    chk("t4_addr1_wrap", 64'(wlog_a[1]), 64'h0);
    chk("t4_done_cycle", 64'(done_idx), 64'd9);
    chk("t4_done_count", 64'(done_cnt), 64'd1);

    // Zero-beat request, then an over-long request that must clamp
    w_tab = '{1, 1, 1, 1};
    push_txn(1'b0, $urandom, 32'($urandom), 3'd0, 1'($urandom));
    drain();
    chk("t5_zero_done_cycle", 64'(done_idx), 64'd1);
    chk("t5_zero_rdata", 64'(o_rdata), 64'd0);
    rb_tab = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    push_txn(1'b0, 32'h0000_0800, 32'($urandom), 3'd7, 1'b0);
    drain();
    chk("t5_clamp_done_cycle", 64'(done_idx), 64'd9);
    chk("t5_clamp_rdata", 64'(o_rdata), 64'hD4C3_B2A1);

    // Randomised traffic, back-to-back requests
    for (int t = 0; t < 30; t++) begin
      for (int k = 0; k < MB; k++) begin
        w_tab[k]  = int'($urandom_range(1, 3));
        rb_tab[k] = DW'($urandom);
      end
      push_txn(1'($urandom), $urandom, 32'($urandom), BW'($urandom_range(0, 7)), 1'($urandom));
      drain();
    end

`ifdef BUS_TIMEOUT_EN
    // Slave never answers beat 1 of a 4-beat load
    w_tab = '{1, 0, 1, 1};
    rb_tab = '{8'h5A, 8'h66, 8'h77, 8'h88};
    push_txn(1'b0, 32'h0000_2000, 32'($urandom), 3'd4, 1'b0);
    drain();
    chk("t6_rdata_partial", 64'(o_rdata), 64'h5A);
    chk("t6_done_cycle", 64'(done_idx), 64'd11);
    chk("t6_error_seen", 64'(err_seen), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cpu_bus_master.md
Name: cpu_bus_master

Overview:
- Parametrised bus-transfer engine between the CPU core's load/store sequencer and the external memory bus.
- Replaces single-byte transfers with multi-beat transfers of up to MAX_BEATS bus beats, with ascending or descending (stack push/pull) address order.
- Assembles or splits wide 65832 operands and performs the o_bus_clk / i_bus_data_ready handshake.
- The core issues one request, then waits for o_done.

Parameters:
ADDR_WIDTH, 32, bus address width.
DATA_WIDTH, 8, bits per bus beat.
MAX_BEATS, 4, maximum beats per request (operand width = MAX_BEATS*DATA_WIDTH).
BEAT_W, 3, width of beat-count field; must hold MAX_BEATS.
TIMEOUT_CYCLES, 255, ready-wait limit (used only with BUS_TIMEOUT_EN).

Ports:
i_clk  in  1  system clock, all logic on rising edge.
i_rst_n  in  1  asynchronous active-low reset.
i_req  in  1  transfer request; sampled only in IDLE.
i_we  in  1  1 = store, 0 = load.
i_addr  in  ADDR_WIDTH  start address.
i_wdata  in  MAX_BEATS*DATA_WIDTH  store operand, little-endian.
i_beats  in  BEAT_W  beat count, 0..MAX_BEATS.
i_descend  in  1  1 = addresses decrement from i_addr (stack push).
o_busy  out  1  high from acceptance until o_done cycle inclusive.
o_done  out  1  one-cycle completion pulse.
o_error  out  1  one-cycle pulse with o_done on timeout abort.
o_rdata  out  MAX_BEATS*DATA_WIDTH  assembled load data.
o_bus_clk  out  1  bus strobe.
o_bus_we  out  1  bus write enable.
o_bus_addr  out  ADDR_WIDTH  bus address.
o_bus_data  out  DATA_WIDTH  bus write data.
i_bus_data  in  DATA_WIDTH  bus read data.
i_bus_data_ready  in  1  slave completion for current beat.

Behaviour:
- Reset:
  - While i_rst_n is low, all outputs and internal state are 0; the FSM is in IDLE.
  - Reset takes effect immediately even mid-transfer: o_bus_clk drops asynchronously and the partial transfer is discarded with no o_done.
- FSM states: IDLE, STROBE, RELEASE, DONE.
- IDLE:
  - i_req=1 latches i_we, i_addr, i_wdata, i_beats and i_descend; clears o_rdata to 0; sets beat counter k=0; asserts o_busy.
  - If i_beats is 0: go to DONE, with no bus activity.
  - If i_beats is greater than MAX_BEATS: clamp to MAX_BEATS.
  - Otherwise: go to STROBE.
- STROBE:
  - o_bus_clk=1 and o_bus_we=latched we.
  - Ascending: o_bus_addr = addr + k. Descending: o_bus_addr = addr - k. Both wrap modulo 2^ADDR_WIDTH.
  - Byte index b = k when ascending, b = beats-1-k when descending, so memory image is always little-endian.
  - Store: o_bus_data = wdata[b*DATA_WIDTH +: DATA_WIDTH].
  - On the cycle i_bus_data_ready=1: for loads, capture i_bus_data into o_rdata byte b; then go to RELEASE.
- RELEASE:
  - o_bus_clk=0 for exactly one cycle; o_bus_addr and o_bus_data hold.
  - Increment k. If k = beats, go to DONE; otherwise go to STROBE.
- DONE: o_done=1 for one cycle, o_busy drops the next cycle, return to IDLE.
- Latency:
  - Accept at cycle 0; strobe rises at cycle 1.
  - Each beat takes 2 cycles plus (ready wait - 1).
  - An N-beat transfer with zero-wait slave (ready seen in first STROBE cycle) completes with o_done at cycle 2N+1.
- i_bus_data_ready is ignored outside STROBE.
- i_req is ignored while o_busy.
- A new request may be presented in the cycle after o_done.
- o_rdata holds its value until the next accepted request.
- Unfilled upper bytes of o_rdata read 0.
- o_bus_we returns to 0 in IDLE.

Optional Feature:
BUS_TIMEOUT_EN:
- Defined:
  - A wait counter is cleared on each STROBE entry and counts STROBE cycles without ready.
  - When the count reaches TIMEOUT_CYCLES, abort: o_bus_clk drops, go to DONE, and o_done and o_error pulse together.
  - Remaining beats are skipped; o_rdata keeps bytes already captured.
- Undefined: no counter; STROBE waits indefinitely; o_error is tied 0.

Test Plan:
1. Reset mid-STROBE of a store → o_bus_clk, o_bus_we, o_busy, o_done all 0 asynchronously; after release, no o_done and FSM in IDLE.
2. Load, i_addr=0x00001000, beats=4, ascending, slave returns 0x11,0x22,0x33,0x44 with zero wait → addresses 0x1000..0x1003, o_rdata=0x44332211, o_done at cycle 9.
3. Store push, i_addr=0x000001FF, beats=4, descend, wdata=0xAABBCCDD → writes 0xAA@0x1FF, 0xBB@0x1FE, 0xCC@0x1FD, 0xDD@0x1FC; o_bus_we=1 throughout STROBE.
4. Store, beats=2, i_addr=0xFFFFFFFF, ascending, ready delayed 3 cycles per beat → second address wraps to 0x00000000; each strobe held 3 cycles; o_done once.
5. beats=0 request → no o_bus_clk pulse, o_done at cycle 1; beats=7 → clamped to 4 beats; i_req during busy → ignored.
6. BUS_TIMEOUT_EN with TIMEOUT_CYCLES=8, ready never asserted on beat 2 of a 4-beat load → strobe drops after 8 cycles, o_done=o_error=1 same cycle, o_rdata holds only byte 0.
